page_xfer_sequencer: RTL and testbench
======================================

PAGE_XFER_SEQUENCER -- requirements
Module: page_xfer_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, page-buffer word-address width.
REQ-002 SHALL have parameter ACK_TMO, default 8, maximum cycles from io_activate to io_busy high.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 SHALL have port dir  input  1  0 = buffer-to-NAND (write), 1 = NAND-to-buffer (read); captured with start.
REQ-007 SHALL have port length  input  ADDR_W+1  word count; captured with start.
REQ-008 SHALL have port buf_addr  output  ADDR_W  page-buffer address.
REQ-009 SHALL have port buf_rdata  input  16  page-buffer read data, valid one cycle after buf_addr.
REQ-010 SHALL have port buf_wdata / buf_we  output  16 / 1  page-buffer write data and strobe.
REQ-011 SHALL have port io_activate  output  1  one-cycle pulse to the downstream IO unit.
REQ-012 SHALL have port io_wdata  output  16  word to the IO unit data input.
REQ-013 SHALL have port io_rdata / io_busy  input  16 / 1  IO unit data output and busy.
REQ-014 SHALL have port busy / done / error  output  1 each  transfer active / one-cycle completion pulse / ack timeout.
REQ-015 SHALL have port count  output  ADDR_W+1  words completed in the current or last transfer.

Function
REQ-016 SHALL have states IDLE, FETCH, LOAD, ISSUE, WAIT_ACK, WAIT_IDLE, STORE, FINISH.
REQ-017 IDLE: start=1 with length>0 SHALL capture dir and length, clear count, buf_addr and error, and go to FETCH (dir=0) or ISSUE (dir=1).
REQ-018 start=1 with length=0 SHALL pulse done the next cycle without issuing io_activate.
REQ-019 FETCH SHALL present buf_addr for one cycle; LOAD SHALL register buf_rdata into io_wdata, then go to ISSUE.
REQ-020 ISSUE SHALL assert io_activate for exactly one cycle, then go to WAIT_ACK.
REQ-021 WAIT_ACK SHALL go to WAIT_IDLE when io_busy=1; after ACK_TMO cycles without it, it SHALL set error (sticky until next start) and go to FINISH.
REQ-022 WAIT_IDLE SHALL wait for io_busy=0, then go to STORE (read) or increment count (write).
REQ-023 STORE SHALL drive buf_we=1 for one cycle with buf_wdata=io_rdata at the current buf_addr, then increment count.
REQ-024 After incrementing count, if count equals length the sequencer SHALL go to FINISH; otherwise it SHALL increment buf_addr and go to FETCH (write) or ISSUE (read).
REQ-025 buf_addr SHALL wrap modulo 2^ADDR_W; length=2^ADDR_W SHALL transfer the full buffer.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-028 Per-word latency SHALL be 2 (write) or 1 (read) cycles plus the IO-unit busy time plus 2 handshake cycles.

Reset
REQ-029 reset SHALL force IDLE and clear all outputs and registers to 0 immediately, including mid-transfer; no io_activate or buf_we SHALL follow deassertion.

Configuration
REQ-030 With XFER_CHECKSUM_EN defined, the block SHALL add output checksum (16 bits): XOR of all words moved, cleared on accepted start and on reset.
REQ-031 Without XFER_CHECKSUM_EN, the checksum port and logic SHALL be absent.

Structure
REQ-032 The state enum, ACK_TMO default and the dir encodings SHALL live in shared package nand_pkg.
REQ-033 The ack-timeout counter SHALL be sub-module xfer_timeout (load, tick, expired).

Verification
REQ-034 Write, length=4, buffer 0x1111..0x4444, IO model busy for 3 cycles -> 4 io_activate pulses with io_wdata 0x1111..0x4444 in order, then done, count=4.
REQ-035 Read, length=3, IO model returns 0xA5A5, 0x5A5A, 0x0F0F -> buf_we at addresses 0,1,2 with those values, done, count=3.
REQ-036 start with length=0 -> done one cycle later, no io_activate, busy never asserts.
REQ-037 IO model never raises io_busy -> error=1 eight cycles after io_activate, done pulses, count=0.
REQ-038 reset asserted during WAIT_IDLE of word 2 -> all outputs 0 that cycle; a new start afterwards runs normally.
REQ-039 With XFER_CHECKSUM_EN, write 0x00FF, 0xFF00 -> checksum=0xFFFF at done.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared definitions for the NAND page-transfer sequencer: FSM states,
// default ack timeout and transfer-direction encodings.
package nand_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      ISSUE,
      WAIT_ACK,
      WAIT_IDLE,
      STORE,
      FINISH
   } xfer_state_t;

   localparam int ACK_TMO_DEFAULT = 8;

   localparam logic DIR_WRITE = 1'b0;  // page buffer -> NAND
   localparam logic DIR_READ  = 1'b1;  // NAND -> page buffer

endpackage

// File: rtl/xfer_timeout.sv
// Down-counter guarding the IO-unit acknowledge. load arms it, tick counts a
// waiting cycle, expired flags the last allowed waiting cycle (LIMIT >= 1).
module xfer_timeout #(
   parameter int LIMIT = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic tick,
   output logic expired
);

   localparam int W = $clog2(LIMIT + 2);

   logic [W-1:0] cnt;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the values from before the clock edge, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= W'(LIMIT);
      else if (tick && cnt != '0)
         cnt <= cnt - W'(1);
   end

   assign expired = tick && (cnt == W'(1));

endmodule

// File: rtl/page_xfer_sequencer.sv
// Moves words between the page buffer and the NAND IO unit, one handshake
// per word. Optional XOR checksum output when XFER_CHECKSUM_EN is defined.
module page_xfer_sequencer
   import nand_pkg::*;
#(
   parameter int ADDR_W  = 12,
   parameter int ACK_TMO = ACK_TMO_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dir,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] buf_addr,
   input  logic [15:0]       buf_rdata,
   output logic [15:0]       buf_wdata,
   output logic              buf_we,
   output logic              io_activate,
   output logic [15:0]       io_wdata,
   input  logic [15:0]       io_rdata,
   input  logic              io_busy,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   count
`ifdef XFER_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   xfer_state_t     state;
   logic            dir_q;
   logic [ADDR_W:0] len_q;
   logic [ADDR_W:0] count_inc;
   logic            tmo_load;
   logic            tmo_tick;
   logic            tmo_expired;
   logic            read_capture;
   logic            word_done;

   assign count_inc    = count + (ADDR_W + 1)'(1);
   assign tmo_load     = (state == ISSUE);
   assign tmo_tick     = (state == WAIT_ACK);
   assign read_capture = (state == WAIT_IDLE) && !io_busy && (dir_q == DIR_READ);
   assign word_done    = (state == STORE) ||
                         ((state == WAIT_IDLE) && !io_busy && (dir_q == DIR_WRITE));

   // The io_activate cycle itself counts toward the timeout window.
   xfer_timeout #(
      .LIMIT (ACK_TMO - 1)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .load    (tmo_load),
      .tick    (tmo_tick),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         dir_q       <= DIR_WRITE;
         len_q       <= '0;
         buf_addr    <= '0;
         buf_wdata   <= '0;
         buf_we      <= 1'b0;
         io_activate <= 1'b0;
         io_wdata    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         count       <= '0;
      end else begin
         // NOTE: strobes default low here and are raised only on the edge that
         // enters the state owning them, giving exact one-cycle pulses.
         io_activate <= 1'b0;
         buf_we      <= 1'b0;
         done        <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  dir_q    <= dir;
                  len_q    <= length;
                  count    <= '0;
                  buf_addr <= '0;
                  error    <= 1'b0;
                  if (length == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy <= 1'b1;
                     if (dir == DIR_WRITE) begin
                        state <= FETCH;
                     end else begin
                        state       <= ISSUE;
                        io_activate <= 1'b1;
                     end
                  end
               end
            end
            FETCH: state <= LOAD;
            LOAD: begin
               io_wdata    <= buf_rdata;
               io_activate <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: state <= WAIT_ACK;
            WAIT_ACK: begin
               if (io_busy) begin
                  state <= WAIT_IDLE;
               end else if (tmo_expired) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            WAIT_IDLE: begin
               if (read_capture) begin
                  buf_we    <= 1'b1;
                  buf_wdata <= io_rdata;
                  state     <= STORE;
               end
            end
            STORE: ;
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (word_done) begin
            count <= count_inc;
            if (count_inc == len_q) begin
               done  <= 1'b1;
               state <= FINISH;
            end else begin
               buf_addr <= buf_addr + ADDR_W'(1);
               if (dir_q == DIR_WRITE) begin
                  state <= FETCH;
               end else begin
                  io_activate <= 1'b1;
                  state       <= ISSUE;
               end
            end
         end
      end
   end

`ifdef XFER_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         checksum <= '0;
      else if (state == IDLE && start)
         checksum <= '0;
      else if (state == LOAD)
         checksum <= checksum ^ buf_rdata;
      else if (read_capture)
         checksum <= checksum ^ io_rdata;
   end
`endif

endmodule

// File: tb/tb_page_xfer_sequencer.sv
// Directed self-checking bench for page_xfer_sequencer with a page-buffer
// model and an IO-unit model whose busy time is three cycles.
module tb_page_xfer_sequencer;

   localparam int AW = 3;

   logic          clk;
   logic          reset;
   logic          start;
   logic          dir;
   logic [AW:0]   length;
   logic [AW-1:0] buf_addr;
   logic [15:0]   buf_rdata;
   logic [15:0]   buf_wdata;
   logic          buf_we;
   logic          io_activate;
   logic [15:0]   io_wdata;
   logic [15:0]   io_rdata;
   logic          io_busy;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   count;
`ifdef XFER_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   int errors = 0;
   int checks = 0;

   logic [15:0]   mem [8];
   logic [15:0]   rd_vals [16];
   int            rd_i;
   bit            model_ack;

   logic [15:0]   act_log [32];
   int            act_n;
   logic [AW-1:0] we_addr [32];
   logic [15:0]   we_data [32];
   int            we_n;

   page_xfer_sequencer #(
      .ADDR_W (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .dir         (dir),
      .length      (length),
      .buf_addr    (buf_addr),
      .buf_rdata   (buf_rdata),
      .buf_wdata   (buf_wdata),
      .buf_we      (buf_we),
      .io_activate (io_activate),
      .io_wdata    (io_wdata),
      .io_rdata    (io_rdata),
      .io_busy     (io_busy),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .count       (count)
`ifdef XFER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Page buffer: data follows the address presented in the previous half cycle.
   initial begin
      buf_rdata = '0;
      forever begin
         @(negedge clk);
         buf_rdata = mem[buf_addr];
      end
   end

   // IO unit: busy for three cycles after each activate, then presents read data.
   initial begin
      io_busy  = 1'b0;
      io_rdata = '0;
      forever begin
         @(negedge clk);
         if (io_activate === 1'b1 && model_ack) begin
            io_busy = 1'b1;
            repeat (3) @(negedge clk);
            io_busy  = 1'b0;
            io_rdata = rd_vals[rd_i];
            if (rd_i < 15) rd_i++;
         end
      end
   end

   initial begin
      act_n = 0;
      we_n  = 0;
      forever begin
         @(negedge clk);
         if (io_activate === 1'b1) begin
            if (act_n < 32) act_log[act_n] = io_wdata;
            act_n++;
         end
         if (buf_we === 1'b1) begin
            if (we_n < 32) begin
               we_addr[we_n] = buf_addr;
               we_data[we_n] = buf_wdata;
            end
            we_n++;
         end
      end
   end

   task automatic do_start(input logic d, input logic [AW:0] len);
      @(negedge clk);
      act_n  = 0;
      we_n   = 0;
      rd_i   = 0;
      start  = 1'b1;
      dir    = d;
      length = len;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int cyc = 0;
      while (done !== 1'b1 && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, cyc);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({busy, done, error, io_activate, buf_we} !== 5'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b, required 00000", {busy, done, error, io_activate, buf_we});
      end
      checks++;
      if (count !== '0 || buf_addr !== '0 || io_wdata !== '0 || buf_wdata !== '0) begin
         errors++;
         $display("FAIL reset_data: count=%h addr=%h io_wdata=%h buf_wdata=%h, required 0", count, buf_addr, io_wdata, buf_wdata);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || io_activate !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b io_activate=%b, required 0 0", busy, io_activate);
      end
   endtask

   task automatic test_write();
      logic [15:0] exp [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) mem[i] = exp[i];
      do_start(1'b0, 4'd4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL write_busy: got %b, required 1", busy);
      end
      wait_done("write");
      checks++;
      if (count !== 4'd4) begin
         errors++;
         $display("FAIL write_count: got %0d, required 4", count);
      end
      checks++;
      if (act_n !== 4) begin
         errors++;
         $display("FAIL write_activates: got %0d, required 4", act_n);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (act_log[i] !== exp[i]) begin
            errors++;
            $display("FAIL write_word%0d: got %h, required %h", i, act_log[i], exp[i]);
         end
      end
      checks++;
      if (we_n !== 0) begin
         errors++;
         $display("FAIL write_no_we: got %0d strobes, required 0", we_n);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL write_end: done=%b busy=%b, required 0 0", done, busy);
      end
   endtask

   task automatic test_read();
      logic [15:0] exp [3] = '{16'hA5A5, 16'h5A5A, 16'h0F0F};
      for (int i = 0; i < 3; i++) rd_vals[i] = exp[i];
      do_start(1'b1, 4'd3);
      wait_done("read");
      checks++;
      if (count !== 4'd3 || error !== 1'b0) begin
         errors++;
         $display("FAIL read_count: count=%0d error=%b, required 3 0", count, error);
      end
      checks++;
      if (we_n !== 3) begin
         errors++;
         $display("FAIL read_strobes: got %0d, required 3", we_n);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (we_addr[i] !== AW'(i) || we_data[i] !== exp[i]) begin
            errors++;
            $display("FAIL read_word%0d: addr=%0d data=%h, required addr=%0d data=%h", i, we_addr[i], we_data[i], i, exp[i]);
         end
      end
   endtask

   task automatic test_zero_length();
      do_start(1'b0, 4'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b busy=%b, required 1 0", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: done=%b busy=%b, required 0 0", done, busy);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (act_n !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_no_activate: activates=%0d busy=%b, required 0 0", act_n, busy);
      end
   endtask

   task automatic test_timeout();
      int cyc = 0;
      model_ack = 1'b0;
      do_start(1'b1, 4'd1);
      while (io_activate !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (io_activate !== 1'b1) begin
         errors++;
         $display("FAIL tmo_activate: io_activate=%b, required 1", io_activate);
      end
      cyc = 0;
      while (error !== 1'b1 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 8) begin
         errors++;
         $display("FAIL tmo_latency: error after %0d cycles, required 8", cyc);
      end
      checks++;
      if (done !== 1'b1 || count !== '0) begin
         errors++;
         $display("FAIL tmo_done: done=%b count=%0d, required 1 0", done, count);
      end
      @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL tmo_sticky: error=%b busy=%b, required 1 0", error, busy);
      end
      model_ack = 1'b1;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      int cyc = 0;
      for (int i = 0; i < 4; i++) mem[i] = 16'h1111 * 16'(i + 1);
      do_start(1'b0, 4'd4);
      checks++;
      if (error !== 1'b0) begin
         errors++;
         $display("FAIL mid_error_cleared: got %b, required 0", error);
      end
      while (pulses < 2 && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (io_activate === 1'b1) pulses++;
      end
      repeat (2) @(negedge clk);
      checks++;
      if (io_busy !== 1'b1 || count !== 4'd1 || io_wdata !== 16'h2222) begin
         errors++;
         $display("FAIL mid_position: io_busy=%b count=%0d io_wdata=%h, required 1 1 2222", io_busy, count, io_wdata);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, done, error, io_activate, buf_we} !== 5'b0) begin
         errors++;
         $display("FAIL mid_strobes: got %b, required 00000", {busy, done, error, io_activate, buf_we});
      end
      checks++;
      if (count !== '0 || buf_addr !== '0 || io_wdata !== '0 || buf_wdata !== '0) begin
         errors++;
         $display("FAIL mid_data: count=%h addr=%h io_wdata=%h buf_wdata=%h, required 0", count, buf_addr, io_wdata, buf_wdata);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      act_n = 0;
      we_n  = 0;
      repeat (6) @(negedge clk);
      checks++;
      if (act_n !== 0 || we_n !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_quiet: activates=%0d strobes=%0d busy=%b, required 0 0 0", act_n, we_n, busy);
      end
      do_start(1'b0, 4'd2);
      wait_done("mid_restart");
      checks++;
      if (count !== 4'd2 || act_n !== 2 || act_log[1] !== 16'h2222) begin
         errors++;
         $display("FAIL mid_restart: count=%0d activates=%0d word1=%h, required 2 2 2222", count, act_n, act_log[1]);
      end
   endtask

   task automatic test_back_to_back();
      mem[0] = 16'h00FF;
      mem[1] = 16'hFF00;
      do_start(1'b0, 4'd2);
      repeat (3) @(negedge clk);
      start  = 1'b1;
      dir    = 1'b1;
      length = 4'd5;
      @(negedge clk);
      start  = 1'b0;
      wait_done("b2b_write");
      checks++;
      if (count !== 4'd2 || act_n !== 2 || act_log[0] !== 16'h00FF || act_log[1] !== 16'hFF00) begin
         errors++;
         $display("FAIL b2b_ignore_start: count=%0d activates=%0d w0=%h w1=%h, required 2 2 00ff ff00", count, act_n, act_log[0], act_log[1]);
      end
`ifdef XFER_CHECKSUM_EN
      checks++;
      if (checksum !== 16'hFFFF) begin
         errors++;
         $display("FAIL checksum_write: got %h, required ffff", checksum);
      end
`endif
      rd_vals[0] = 16'hBEEF;
      do_start(1'b1, 4'd1);
      wait_done("b2b_read");
      checks++;
      if (count !== 4'd1 || we_n !== 1 || we_data[0] !== 16'hBEEF) begin
         errors++;
         $display("FAIL b2b_read: count=%0d strobes=%0d data=%h, required 1 1 beef", count, we_n, we_data[0]);
      end
   endtask

   task automatic test_full_buffer();
      for (int i = 0; i < 8; i++) rd_vals[i] = 16'h0101 * 16'(i + 1);
      do_start(1'b1, 4'd8);
      wait_done("full");
      checks++;
      if (count !== 4'd8 || we_n !== 8) begin
         errors++;
         $display("FAIL full_count: count=%0d strobes=%0d, required 8 8", count, we_n);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (we_addr[i] !== AW'(i) || we_data[i] !== 16'h0101 * 16'(i + 1)) begin
            errors++;
            $display("FAIL full_word%0d: addr=%0d data=%h, required addr=%0d data=%h", i, we_addr[i], we_data[i], i, 16'h0101 * 16'(i + 1));
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      dir       = 1'b0;
      length    = '0;
      model_ack = 1'b1;
      rd_i      = 0;
      for (int i = 0; i < 8; i++) mem[i] = '0;
      for (int i = 0; i < 16; i++) rd_vals[i] = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_zero_length();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_full_buffer();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
